// File: rtl/apb_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_ram_arbiter
// Description : APB master with a round-robin front end. NUM_REQ requesters
//               share one APB RAM slave through valid/ready request ports and
//               receive a one-cycle response pulse. A wait-state timeout aborts
//               ACCESS when the slave never raises PREADY.
// Ports       : PCLK, PRESET           clock, synchronous active-high reset
//               req_valid/req_write    per-requester request valid / direction
//               req_addr/req_wdata     flattened request address / write data
//               req_ready              one-hot combinational accept (IDLE only)
//               rsp_valid              one-hot one-cycle response pulse
//               rsp_rdata/rsp_err      response data / error, held between pulses
//               PSEL..PWDATA           APB master request outputs (registered)
//               PRDATA/PREADY/PSLVERR  APB slave response inputs
// Revision    : 1.0 - initial release
// ============================================================================
module apb_ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        grant_q;
  logic [CNT_W-1:0]        tmo_cnt_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  logic [IDX_W-1:0]        win_idx;
  logic                    win_vld;
  logic [IDX_W-1:0]        rr_ptr_d;
  logic [NUM_REQ-1:0]      grant_oh;

  // Requester index at offset k from base, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan offsets from the far end down so the requester closest to rr_ptr
  // (smallest offset) is the last assignment and therefore wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(rr_ptr_q, k)]) begin
        win_idx = rr_idx(rr_ptr_q, k);
        win_vld = 1'b1;
      end
    end
  end

  assign rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  always_comb begin
    req_ready = '0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == S_IDLE) && win_vld && (win_idx == IDX_W'(i));
      grant_oh[i]  = (grant_q == IDX_W'(i));
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tmo_cnt_q   <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // Response is a single-cycle pulse; data/error hold until the next one.
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            grant_q   <= win_idx;
            pwrite_q  <= req_write[win_idx];
            paddr_q   <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_q  <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY is tested first so it wins over a simultaneous timeout.
          if (PREADY) begin
            rsp_valid_q <= grant_oh;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid_q <= grant_oh;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire
